// File: rtl/multi_pwm_timer.sv
// N-channel PWM generator sharing one prescaler. Period/hold writes land in shadow
// registers and reach the active copy only at a period wrap, an enable, or a sync.
module multi_pwm_timer #(
    parameter int PRESCALE_TICKS = 600,
    parameter int N_CH           = 4,
    parameter int CNT_W          = 16,
    parameter int DEF_PERIOD     = 40000,
    parameter int DEF_HOLD       = 6000
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                cfg_addr,
    input  logic [CNT_W-1:0]                          cfg_wdata,
    input  logic                                      sync,
    output logic                                      tick,
    output logic [N_CH-1:0]                           pwm,
    output logic [N_CH-1:0]                           wrap
);

    localparam int               CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int               PS_W       = $clog2(PRESCALE_TICKS);
    localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(PRESCALE_TICKS - 1);
    localparam logic [CNT_W-1:0] DEF_PER_V  = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_HOLD_V = CNT_W'(DEF_HOLD);
    localparam logic [1:0]       A_PERIOD   = 2'd0;
    localparam logic [1:0]       A_HOLD     = 2'd1;
    localparam logic [1:0]       A_CTRL     = 2'd2;

    logic [PS_W-1:0]  ps_q, ps_d;
    logic             adv;
    logic [CNT_W-1:0] cnt_q      [N_CH];
    logic [CNT_W-1:0] cnt_d      [N_CH];
    logic [CNT_W-1:0] per_shd_q  [N_CH];
    logic [CNT_W-1:0] per_shd_d  [N_CH];
    logic [CNT_W-1:0] per_act_q  [N_CH];
    logic [CNT_W-1:0] per_act_d  [N_CH];
    logic [CNT_W-1:0] hold_shd_q [N_CH];
    logic [CNT_W-1:0] hold_shd_d [N_CH];
    logic [CNT_W-1:0] hold_act_q [N_CH];
    logic [CNT_W-1:0] hold_act_d [N_CH];
    logic [N_CH-1:0]  en_q, en_d;
    logic [N_CH-1:0]  inv_q, inv_d;
    logic [N_CH-1:0]  pwm_q, pwm_d;

    // Shared prescaler; sync restarts it and suppresses channel advance that clk.
    always_comb begin
        tick = (ps_q == PS_LAST);
        adv  = tick & ~sync;
        if (sync || tick) begin
            ps_d = '0;
        end else begin
            ps_d = ps_q + 1'b1;
        end
    end

    always_comb begin
        logic hit;
        logic restart;
        logic at_end;
        hit     = 1'b0;
        restart = 1'b0;
        at_end  = 1'b0;
        wrap    = '0;
        en_d    = en_q;
        inv_d   = inv_q;
        pwm_d   = pwm_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]      = cnt_q[i];
            per_shd_d[i]  = per_shd_q[i];
            per_act_d[i]  = per_act_q[i];
            hold_shd_d[i] = hold_shd_q[i];
            hold_act_d[i] = hold_act_q[i];

            hit     = cfg_we && (cfg_ch == CH_W'(i));
            restart = (sync && en_q[i]) ||
                      (hit && (cfg_addr == A_CTRL) && cfg_wdata[0] && !en_q[i]);
            // A zero period behaves as period 1: every tick is a wrap.
            at_end  = (per_act_q[i] == '0) || (cnt_q[i] >= per_act_q[i] - 1'b1);
            wrap[i] = en_q[i] && adv && at_end;

            pwm_d[i] = en_q[i] ? ((cnt_q[i] < hold_act_q[i]) ^ inv_q[i]) : inv_q[i];

            if (restart || wrap[i]) begin
                cnt_d[i]      = '0;
                per_act_d[i]  = per_shd_q[i];
                hold_act_d[i] = hold_shd_q[i];
            end else if (!en_q[i]) begin
                cnt_d[i] = '0;
            end else if (adv) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            // Shadow writes never disturb the active copy loaded above in the same clk.
            if (hit) begin
                case (cfg_addr)
                    A_PERIOD: per_shd_d[i]  = cfg_wdata;
                    A_HOLD:   hold_shd_d[i] = cfg_wdata;
                    A_CTRL: begin
                        en_d[i]  = cfg_wdata[0];
                        inv_d[i] = cfg_wdata[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q  <= '0;
            en_q  <= '0;
            inv_q <= '0;
            pwm_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]      <= '0;
                per_shd_q[i]  <= DEF_PER_V;
                per_act_q[i]  <= DEF_PER_V;
                hold_shd_q[i] <= DEF_HOLD_V;
                hold_act_q[i] <= DEF_HOLD_V;
            end
        end else begin
            ps_q  <= ps_d;
            en_q  <= en_d;
            inv_q <= inv_d;
            pwm_q <= pwm_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]      <= cnt_d[i];
                per_shd_q[i]  <= per_shd_d[i];
                per_act_q[i]  <= per_act_d[i];
                hold_shd_q[i] <= hold_shd_d[i];
                hold_act_q[i] <= hold_act_d[i];
            end
        end
    end

    assign pwm = pwm_q;

endmodule

// File: tb/tb_multi_pwm_timer.sv
// Bench for multi_pwm_timer: directed table of configurations measured per period,
// hand-timed corner sequences, and a randomized run against a behavioural model.
module tb_multi_pwm_timer;

    localparam int PT = 4;
    localparam int NC = 2;
    localparam int DEFP = 10;
    localparam int DEFH = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_we = 1'b0;
    logic [0:0] cfg_ch = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_wdata = 8'd0;
    logic       sync = 1'b0;
    logic       tick;
    logic [1:0] pwm;
    logic [1:0] wrap;

    multi_pwm_timer #(
        .PRESCALE_TICKS(PT), .N_CH(NC), .CNT_W(8), .DEF_PERIOD(DEFP), .DEF_HOLD(DEFH)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .sync(sync), .tick(tick), .pwm(pwm), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc_n = 0;
    bit       o_tick;
    bit [1:0] o_pwm;
    bit [1:0] o_wrap;

    // Behavioural model state: plain integers per channel.
    int m_ps;
    int m_cnt[NC];
    int m_per_shd[NC];
    int m_per_act[NC];
    int m_hold_shd[NC];
    int m_hold_act[NC];
    bit [NC-1:0] m_en;
    bit [NC-1:0] m_inv;
    bit [NC-1:0] m_pwm;

    typedef struct {
        int ch;
        int addr;
        int wdata;
        int exp_per;
        int exp_hi;
    } row_t;
    row_t rows[12];

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc_n);
        end
    endtask

    task automatic m_reset();
        m_ps = 0;
        m_en = '0;
        m_inv = '0;
        m_pwm = '0;
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0;
            m_per_shd[i] = DEFP;
            m_per_act[i] = DEFP;
            m_hold_shd[i] = DEFH;
            m_hold_act[i] = DEFH;
        end
    endtask

    function automatic int ticks_per_period(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    task automatic m_outputs(output bit e_tick, output bit [1:0] e_pwm, output bit [1:0] e_wrap);
        e_tick = (m_ps == PT - 1);
        e_pwm = m_pwm;
        for (int i = 0; i < NC; i++)
            e_wrap[i] = m_en[i] && e_tick && !sync &&
                        (m_cnt[i] + 1 >= ticks_per_period(m_per_act[i]));
    endtask

    task automatic m_step();
        bit t;
        bit [1:0] p;
        bit [1:0] w;
        bit hit;
        m_outputs(t, p, w);
        for (int i = 0; i < NC; i++)
            m_pwm[i] = m_en[i] ? ((m_cnt[i] < m_hold_act[i]) ^ m_inv[i]) : m_inv[i];
        for (int i = 0; i < NC; i++) begin
            hit = cfg_we && (int'(cfg_ch) == i);
            if ((sync && m_en[i]) || (hit && cfg_addr == 2 && cfg_wdata[0] && !m_en[i]) || w[i]) begin
                m_cnt[i] = 0;
                m_per_act[i] = m_per_shd[i];
                m_hold_act[i] = m_hold_shd[i];
            end else if (!m_en[i]) begin
                m_cnt[i] = 0;
            end else if (t && !sync) begin
                m_cnt[i] = m_cnt[i] + 1;
            end
            if (hit) begin
                if (cfg_addr == 0) m_per_shd[i] = int'(cfg_wdata);
                if (cfg_addr == 1) m_hold_shd[i] = int'(cfg_wdata);
                if (cfg_addr == 2) begin
                    m_en[i] = cfg_wdata[0];
                    m_inv[i] = cfg_wdata[1];
                end
            end
        end
        m_ps = sync ? 0 : (m_ps + 1) % PT;
    endtask

    // Observe one clock cycle at the falling edge, then step past the rising edge.
    task automatic cyc();
        bit e_tick;
        bit [1:0] e_pwm;
        bit [1:0] e_wrap;
        @(negedge clk);
        cyc_n++;
        o_tick = tick;
        o_pwm = pwm;
        o_wrap = wrap;
        if (reset) begin
            chk("rst_tick", int'(o_tick), 0);
            chk("rst_pwm", int'(o_pwm), 0);
            chk("rst_wrap", int'(o_wrap), 0);
        end else begin
            m_outputs(e_tick, e_pwm, e_wrap);
            chk("model_tick", int'(o_tick), int'(e_tick));
            chk("model_pwm", int'(o_pwm), int'(e_pwm));
            chk("model_wrap", int'(o_wrap), int'(e_wrap));
            m_step();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int addr, input int data);
        cfg_we = 1'b1;
        cfg_ch = 1'(ch);
        cfg_addr = 2'(addr);
        cfg_wdata = 8'(data);
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic wait_wrap(input int ch, output int at);
        int k;
        at = -1;
        k = 0;
        while (at < 0 && k < 3000) begin
            cyc();
            if (o_wrap[ch]) at = cyc_n;
            k++;
        end
        if (at < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_wrap ch%0d: got no wrap expected one within 3000 clks", ch);
        end
    endtask

    // Counts clocks from just after a wrap up to and including the next wrap.
    task automatic measure(input int ch, output int per, output int hi);
        bit done;
        per = 0;
        hi = 0;
        done = 1'b0;
        while (!done && per < 3000) begin
            cyc();
            per++;
            if (o_pwm[ch]) hi++;
            if (o_wrap[ch]) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL measure ch%0d: got no wrap expected one within 3000 clks", ch);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, w1, w2, w3, per, hi, ticks, wr_c, tk;

        rows[0]  = '{0, 2, 1,   40, 12};
        rows[1]  = '{0, 1, 5,   40, 20};
        rows[2]  = '{0, 0, 6,   24, 20};
        rows[3]  = '{0, 1, 0,   24, 0};
        rows[4]  = '{0, 1, 6,   24, 24};
        rows[5]  = '{0, 0, 0,   4,  4};
        rows[6]  = '{1, 2, 3,   40, 28};
        rows[7]  = '{1, 1, 0,   40, 40};
        rows[8]  = '{1, 1, 10,  40, 0};
        rows[9]  = '{1, 1, 200, 40, 0};
        rows[10] = '{0, 0, 10,  40, 24};
        rows[11] = '{0, 1, 3,   40, 12};

        #2;
        reset = 1'b1;
        m_reset();
        repeat (2) cyc();
        reset = 1'b0;

        for (int r = 0; r < 12; r++) begin
            wr(rows[r].ch, rows[r].addr, rows[r].wdata);
            wait_wrap(rows[r].ch, t);
            wait_wrap(rows[r].ch, t);
            measure(rows[r].ch, per, hi);
            chk($sformatf("row%0d_period_clks", r), per, rows[r].exp_per);
            chk($sformatf("row%0d_high_clks", r), hi, rows[r].exp_hi);
        end

        // Period rewritten mid-period (cnt=4): current period keeps 10 ticks.
        wait_wrap(0, w1);
        ticks = 0;
        for (int k = 0; k < 100 && ticks < 4; k++) begin
            cyc();
            if (o_tick) ticks++;
        end
        wr(0, 0, 5);
        wait_wrap(0, w2);
        wait_wrap(0, w3);
        chk("t3_current_period_clks", w2 - w1, 40);
        chk("t3_next_period_clks", w3 - w2, 20);

        // Hold written in the same clk as a wrap: old shadow applies first.
        wr(0, 0, 10);
        wait_wrap(0, t);
        wait_wrap(0, t);
        repeat (39) cyc();
        cfg_we = 1'b1;
        cfg_ch = 1'b0;
        cfg_addr = 2'd1;
        cfg_wdata = 8'd7;
        cyc();
        cfg_we = 1'b0;
        chk("t4_wrap_in_write_clk", int'(o_wrap[0]), 1);
        measure(0, per, hi);
        chk("t4_next_high_clks", hi, 12);
        measure(0, per, hi);
        chk("t4_following_high_clks", hi, 28);

        // Two channels out of phase, then sync aligns them.
        wr(0, 1, 3);
        wr(1, 1, 3);
        wr(1, 2, 0);
        repeat ($urandom_range(3, 20)) cyc();
        wr(1, 2, 1);
        repeat ($urandom_range(5, 30)) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (k >= 2) chk($sformatf("t5_pwm_k%0d", k), int'(o_pwm), (k <= 13) ? 3 : 0);
            chk($sformatf("t5_wrap_k%0d", k), int'(o_wrap), (k == 40) ? 3 : 0);
            chk($sformatf("t5_tick_k%0d", k), int'(o_tick), (k % 4 == 0) ? 1 : 0);
        end

        // Reset mid-period at cnt=6 with ch0 inverted and tick high.
        wr(0, 2, 3);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        repeat (27) cyc();
        #1;
        chk("t6_pre_tick", int'(tick), 1);
        chk("t6_pre_pwm", int'(pwm), 1);
        reset = 1'b1;
        #1;
        chk("t6_async_tick", int'(tick), 0);
        chk("t6_async_pwm", int'(pwm), 0);
        chk("t6_async_wrap", int'(wrap), 0);
        m_reset();
        repeat (2) cyc();
        reset = 1'b0;
        hi = 0;
        wr_c = 0;
        tk = 0;
        repeat (60) begin
            cyc();
            hi += int'(o_pwm != 2'b00);
            wr_c += $countones(o_wrap);
            tk += int'(o_tick);
        end
        chk("t6_pwm_after_reset", hi, 0);
        chk("t6_wraps_after_reset", wr_c, 0);
        chk("t6_ticks_after_reset", tk, 15);

        // Randomized traffic against the model.
        wr(0, 2, 1);
        wr(1, 2, 1);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                cfg_we = 1'b1;
                cfg_ch = 1'($urandom_range(0, 1));
                cfg_addr = 2'($urandom_range(0, 3));
                if (cfg_addr == 2'd2)
                    cfg_wdata = 8'($urandom_range(0, 3));
                else if ($urandom_range(0, 19) == 0)
                    cfg_wdata = 8'($urandom_range(0, 255));
                else
                    cfg_wdata = 8'($urandom_range(0, 14));
            end
            sync = ($urandom_range(0, 49) == 0);
            cyc();
            cfg_we = 1'b0;
            sync = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
